ram_loader_module: RTL and testbench
====================================

Name: ram_loader_module

Overview:
- Bus master that writes a program image into the RAM over the shared 8-bit bus. It is the writing end of the memory interface that the CPU otherwise only reads during fetch and execute.
- Accepts a byte stream on a valid/ready handshake. Each byte takes two bus transactions: address into the memory address register (MAI), then data into RAM (MI).
- Holds the CPU for the whole load. Sits beside the control module; the top-level ORs its MAI/MI into the control word and gates the CPU clock with hold.

Parameters:
- DEPTH, 16, number of RAM locations; load addresses run 0..DEPTH-1.
- AW, 8, address width driven on the bus; upper bits are zero-extended.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load at address 0.
- byte_i  input  8  program byte.
- byte_valid_i  input  1  byte_i holds a valid byte.
- byte_last_i  input  1  qualified by byte_valid_i; marks the final byte of the image.
- byte_ready_o  output  1  loader accepts byte_i this cycle.
- bus  inout  8  shared bus; driven only in ADDR/DATA, otherwise high-Z.
- mai_o  output  1  memory address register input enable.
- mi_o  output  1  RAM input enable.
- hold_o  output  1  CPU held; the clock is gated and the control word is ignored.
- busy_o  output  1  load in progress.
- done_o  output  1  one-cycle pulse when the load completes.
- count_o  output  8  number of bytes written in the current or most recent load.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; addr=0, data latch=0, count_o=0.
  - mai_o=0, mi_o=0, hold_o=0, busy_o=0, done_o=0, byte_ready_o=0.
  - bus released to Z.
  - A reset mid-load aborts immediately. RAM contents already written stay; no done pulse.
- States: IDLE, WAIT, ADDR, DATA, DONE.
- IDLE:
  - On start=1: go to WAIT; addr=0, count_o=0; hold_o=1 and busy_o=1 from the next cycle.
  - start is ignored in every other state.
- WAIT:
  - byte_ready_o=1 (combinational from state).
  - On byte_valid_i=1, the byte is accepted that edge: latch byte_i, latch byte_last_i into a last flag, go to ADDR.
  - If byte_valid_i=0, stay in WAIT indefinitely; hold_o remains 1.
- ADDR (1 cycle):
  - bus = addr zero-extended to 8 bits; mai_o=1.
  - Next state DATA.
- DATA (1 cycle):
  - bus = latched byte; mi_o=1.
  - At the edge: count_o+=1.
  - If last flag=1 or addr==DEPTH-1, go to DONE.
  - Otherwise addr+=1 and go to WAIT.
- DONE (1 cycle):
  - done_o=1; hold_o=0, busy_o=0 at the next edge.
  - Then go to IDLE.
  - count_o holds its value until the next start.
- Bus drive and enables:
  - mai_o and mi_o are never asserted together.
  - The bus is driven in exactly the cycles mai_o or mi_o is 1.
- Throughput: minimum 3 cycles per byte (WAIT accept, ADDR, DATA); at most 1 byte per 3 cycles.
- Overflow: at DEPTH bytes the load ends even without byte_last_i. The address never wraps, and byte_ready_o stays 0 until the next start.
- Simultaneous events:
  - rst has priority over start and byte_valid_i.
  - start together with byte_valid_i in IDLE: the byte is not accepted (ready=0 in IDLE).
- The hold_o/busy_o window covers WAIT, ADDR and DATA.

Test Plan:
- Reset, then idle: bus=Z, all enables 0, hold_o=0, count_o=0 -> values hold for 20 cycles with no start.
- start, then bytes 0x1E,0x2F,0xE0,0xF0 with last on 0xF0, valid held high -> MAI cycles show bus=0x00..0x03. MI cycles show the bytes in order. done_o is high for one cycle, count_o=4, and RAM[0..3] match when read back via MO.
- Back-pressure: valid low for 5 cycles between bytes -> loader stays in WAIT with hold_o=1; no bus drive; next byte lands at the correct address.
- 18 bytes with no last flag -> writes 16 bytes (addr 0x00..0x0F). done_o fires after byte 16; count_o=16. Bytes 17-18 are never accepted (ready=0).
- rst asserted during an ADDR cycle of byte 3 -> next cycle bus=Z, mai_o=mi_o=hold_o=0, no done_o. RAM[0..1] retain their written values.
- start pulsed again during WAIT, plus rst and start in the same cycle -> mid-load start is ignored with addr unchanged. rst wins and the loader stays IDLE.

Source files
------------

// File: rtl/ram_loader_module_if.sv
// ram_loader_module_if
//   Byte-stream handshake between a program-image source and the RAM loader.
//   byte_i        : program byte
//   byte_valid_i  : byte_i holds a valid byte
//   byte_last_i   : final byte of the image (qualified by byte_valid_i)
//   byte_ready_o  : loader accepts byte_i this cycle
//   master : image source (drives byte/valid/last, observes ready)
//   slave  : loader (observes byte/valid/last, drives ready)
interface ram_loader_module_if;
    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       byte_last_i;
    logic       byte_ready_o;

    modport master (
        output byte_i,
        output byte_valid_i,
        output byte_last_i,
        input  byte_ready_o
    );

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        input  byte_last_i,
        output byte_ready_o
    );
endinterface

// File: rtl/ram_loader_module.sv
// ram_loader_module
//   Bus master that writes a program image into RAM over the shared 8-bit bus.
//   Each accepted byte costs two bus cycles: the address into the memory
//   address register (mai_o), then the data into RAM (mi_o). The CPU is held
//   for the whole load.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous, active-high reset (aborts a load in progress)
//   start    : one-cycle pulse, begins a load at address 0 (IDLE only)
//   byte_if  : byte-stream handshake (slave side)
//   bus      : shared bus, driven only while mai_o or mi_o is high
//   mai_o    : memory address register input enable
//   mi_o     : RAM input enable
//   hold_o   : CPU held (WAIT/ADDR/DATA)
//   busy_o   : load in progress (WAIT/ADDR/DATA)
//   done_o   : one-cycle pulse when a load completes
//   count_o  : bytes written in the current or most recent load
//
// States
//   state  | meaning
//   IDLE   | no load; waiting for start
//   WAIT   | ready for the next byte; holds here while byte_valid_i is low
//   ADDR   | address on the bus, mai_o high
//   DATA   | latched byte on the bus, mi_o high; count advances
//   DONE   | done_o pulse; back to IDLE next cycle
module ram_loader_module #(
    parameter int DEPTH = 16,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    ram_loader_module_if.slave byte_if,
    inout  wire  [7:0]         bus,
    output logic               mai_o,
    output logic               mi_o,
    output logic               hold_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [7:0]         count_o
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;
    logic [7:0]    count_q, count_d;

    logic          ready;
    logic          bus_en;
    logic [7:0]    bus_val;
    logic [AW-1:0] addr_ext;

    // Address as seen on the bus: zero-extended to AW, then placed on 8 bits.
    assign addr_ext = AW'(addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        count_d = count_q;
        ready   = 1'b0;
        mai_o   = 1'b0;
        mi_o    = 1'b0;
        hold_o  = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        bus_en  = 1'b0;
        bus_val = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    addr_d  = '0;
                    count_d = '0;
                end
            end

            S_WAIT: begin
                ready  = 1'b1;
                hold_o = 1'b1;
                busy_o = 1'b1;
                if (byte_if.byte_valid_i) begin
                    data_d  = byte_if.byte_i;
                    last_d  = byte_if.byte_last_i;
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                hold_o  = 1'b1;
                busy_o  = 1'b1;
                mai_o   = 1'b1;
                bus_en  = 1'b1;
                bus_val = 8'(addr_ext);
                state_d = S_DATA;
            end

            S_DATA: begin
                hold_o  = 1'b1;
                busy_o  = 1'b1;
                mi_o    = 1'b1;
                bus_en  = 1'b1;
                bus_val = data_q;
                count_d = count_q + 8'd1;
                // The top RAM location ends the load even without a last
                // flag, so the address never wraps onto earlier bytes.
                if (last_q || (addr_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + CW'(1);
                    state_d = S_WAIT;
                end
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign byte_if.byte_ready_o = ready;
    assign count_o              = count_q;
    assign bus                  = bus_en ? bus_val : 8'bz;

endmodule

// File: tb/tb_ram_loader_module.sv
module tb_ram_loader_module;

    localparam int DEPTH  = 16;
    localparam int K_MAI  = 0;
    localparam int K_MI   = 1;
    localparam int K_DONE = 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    wire  [7:0] bus;
    logic       mai, mi, hold, busy, done;
    logic [7:0] count;

    ram_loader_module_if byte_if ();

    ram_loader_module #(.DEPTH(DEPTH), .AW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .byte_if (byte_if.slave),
        .bus     (bus),
        .mai_o   (mai),
        .mi_o    (mi),
        .hold_o  (hold),
        .busy_o  (busy),
        .done_o  (done),
        .count_o (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] value;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    bit         mon_en      = 1'b0;

    // RAM + memory address register model, fed from the bus enables.
    logic [7:0] ram [DEPTH];
    logic [7:0] mar = 8'h00;

    always @(posedge clk) begin
        if (mai) mar <= bus;
        if (mi)  ram[mar[3:0]] <= bus;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic sb_check(input int kind, input logic [7:0] val, input string name);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected event value 0x%02h, expected no event", name, val);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.value !== val) begin
                miscompares++;
                $display("FAIL %s: got kind %0d value 0x%02h, expected kind %0d value 0x%02h",
                         name, kind, val, e.kind, e.value);
            end
        end
    endtask

    // Monitor: compares every bus/done event against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mai || mi) check("mai_mi_exclusive", 8'(mai & mi), 8'h00);
                if (mai)  sb_check(K_MAI,  bus,   "mai_addr");
                if (mi)   sb_check(K_MI,   bus,   "mi_data");
                if (done) sb_check(K_DONE, count, "done_count");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drop_valid();
        byte_if.byte_valid_i = 1'b0;
        byte_if.byte_last_i  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last,
                             input logic [7:0] exp_addr, input bit exp_mi,
                             input bit exp_done, input logic [7:0] exp_count);
        bit accepted;
        exp_t e;
        e.kind = K_MAI;  e.value = exp_addr;  sb.push_back(e);
        if (exp_mi)   begin e.kind = K_MI;   e.value = d;         sb.push_back(e); end
        if (exp_done) begin e.kind = K_DONE; e.value = exp_count; sb.push_back(e); end
        byte_if.byte_i       = d;
        byte_if.byte_valid_i = 1'b1;
        byte_if.byte_last_i  = last;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (byte_if.byte_ready_o) accepted = 1'b1;
        end
        check("byte_accepted", 8'(accepted), 8'h01);
        tick();
    endtask

    task automatic wait_done(input logic [7:0] exp_count);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 8'(seen), 8'h01);
        tick();
        @(negedge clk);
        check("count_after_done", count, exp_count);
        check("busy_after_done", 8'(busy), 8'h00);
        check("hold_after_done", 8'(hold), 8'h00);
        check("done_single_pulse", 8'(done), 8'h00);
        check("scoreboard_empty", 8'(sb.size()), 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_if.byte_i       = 8'h00;
        drop_valid();

        // Reset, then 20 quiet cycles.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_mai",   8'(mai),                  8'h00);
            check("idle_mi",    8'(mi),                   8'h00);
            check("idle_hold",  8'(hold),                 8'h00);
            check("idle_busy",  8'(busy),                 8'h00);
            check("idle_done",  8'(done),                 8'h00);
            check("idle_ready", 8'(byte_if.byte_ready_o), 8'h00);
            check("idle_count", count,                    8'h00);
        end
        tick();

        // Four-byte image, valid held high.
        pulse_start();
        send_byte(8'h1E, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        send_byte(8'h2F, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00);
        send_byte(8'hE0, 1'b0, 8'h02, 1'b1, 1'b0, 8'h00);
        send_byte(8'hF0, 1'b1, 8'h03, 1'b1, 1'b1, 8'h04);
        drop_valid();
        wait_done(8'h04);
        check("ram0_img1", ram[0], 8'h1E);
        check("ram1_img1", ram[1], 8'h2F);
        check("ram2_img1", ram[2], 8'hE0);
        check("ram3_img1", ram[3], 8'hF0);

        // Back-pressure: valid low for 5 cycles in WAIT.
        pulse_start();
        send_byte(8'h31, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        drop_valid();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold",  8'(hold),                 8'h01);
            check("bp_busy",  8'(busy),                 8'h01);
            check("bp_ready", 8'(byte_if.byte_ready_o), 8'h01);
            check("bp_mai",   8'(mai),                  8'h00);
            check("bp_mi",    8'(mi),                   8'h00);
        end
        tick();
        send_byte(8'h42, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00);
        send_byte(8'h53, 1'b1, 8'h02, 1'b1, 1'b1, 8'h03);
        drop_valid();
        wait_done(8'h03);
        check("ram0_bp", ram[0], 8'h31);
        check("ram1_bp", ram[1], 8'h42);
        check("ram2_bp", ram[2], 8'h53);

        // Overflow: 16 bytes without last, then two more that must be refused.
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h10 + 8'(i), 1'b0, 8'(i), 1'b1, (i == 15), 8'h10);
        end
        byte_if.byte_i       = 8'h77;
        byte_if.byte_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("ovf_ready_b17", 8'(byte_if.byte_ready_o), 8'h00);
        end
        byte_if.byte_i = 8'h88;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ovf_ready_b18", 8'(byte_if.byte_ready_o), 8'h00);
        end
        drop_valid();
        tick();
        check("ovf_count",   count,               8'h10);
        check("ovf_busy",    8'(busy),            8'h00);
        check("ovf_sb_empty", 8'(sb.size()),      8'h00);
        check("ram0_ovf",    ram[0],              8'h10);
        check("ram15_ovf",   ram[15],             8'h1F);

        // Reset during the ADDR cycle of byte 3.
        pulse_start();
        send_byte(8'hA0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        send_byte(8'hA1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00);
        send_byte(8'hA2, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        drop_valid();
        tick();
        @(negedge clk);
        check("rst_mai",   8'(mai),                  8'h00);
        check("rst_mi",    8'(mi),                   8'h00);
        check("rst_hold",  8'(hold),                 8'h00);
        check("rst_busy",  8'(busy),                 8'h00);
        check("rst_done",  8'(done),                 8'h00);
        check("rst_ready", 8'(byte_if.byte_ready_o), 8'h00);
        check("rst_count", count,                    8'h00);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_done", 8'(done), 8'h00);
        end
        check("ram0_rst", ram[0], 8'hA0);
        check("ram1_rst", ram[1], 8'hA1);
        check("ram2_rst", ram[2], 8'h12);
        check("rst_sb_empty", 8'(sb.size()), 8'h00);
        tick();

        // start during WAIT is ignored; second byte goes to address 1.
        pulse_start();
        send_byte(8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        drop_valid();
        tick();
        tick();
        @(negedge clk);
        check("wait_ready", 8'(byte_if.byte_ready_o), 8'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h66, 1'b1, 8'h01, 1'b1, 1'b1, 8'h02);
        drop_valid();
        wait_done(8'h02);
        check("ram0_restart", ram[0], 8'h55);
        check("ram1_restart", ram[1], 8'h66);

        // rst and start together: reset wins, loader stays idle.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_start_busy",  8'(busy),                 8'h00);
            check("rst_start_hold",  8'(hold),                 8'h00);
            check("rst_start_ready", 8'(byte_if.byte_ready_o), 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
